// File: rtl/layer_stream_arbiter_pkg.sv
// Shared definitions for the stream arbiters.
//   arb_state_e : arbiter FSM encoding (IDLE = free to pick, LOCKED = burst owner fixed)
//   arb_clog2   : ceiling log2 usable in parameter expressions
package layer_stream_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for n <= 1, callers clamp where a 1-bit minimum is needed.
  function automatic int unsigned arb_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/layer_stream_arbiter_rr_pick.sv
// Rotating priority pick: finds the first set bit of req at or after ptr,
// wrapping modulo NUM_PORT.
//   req    in  NUM_PORT  request vector
//   ptr    in  PID_W     starting index of the scan (must be < NUM_PORT)
//   onehot out NUM_PORT  one-hot winner, all zero when nothing requests
//   index  out PID_W     winner index, 0 when nothing requests
//   any    out 1         at least one request present
module layer_stream_arbiter_rr_pick #(
  parameter int NUM_PORT = 4,
  parameter int PID_W    = 2
) (
  input  logic [NUM_PORT-1:0] req,
  input  logic [PID_W-1:0]    ptr,
  output logic [NUM_PORT-1:0] onehot,
  output logic [PID_W-1:0]    index,
  output logic                any
);

  int          pos;
  logic [PID_W-1:0] pos_idx;

  // Scan from the farthest offset down to offset 0 so the nearest request
  // at or after ptr is the last one written.
  always_comb begin
    onehot  = '0;
    index   = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_PORT - 1; k >= 0; k--) begin
      pos     = (int'(ptr) + k) % NUM_PORT;
      pos_idx = PID_W'(pos);
      if (req[pos_idx]) begin
        onehot          = '0;
        onehot[pos_idx] = 1'b1;
        index           = pos_idx;
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_stream_arbiter.sv
// Round-robin, burst-locked arbiter merging NUM_PORT producer streams into one
// registered output stream for the next layer.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_rdy   per-producer handshake; in_rdy is at most one-hot
//   in_data           port i occupies [i*BIT_WIDTH +: BIT_WIDTH]
//   next_layer_rdy    consumer ready
//   next_layer_valid  registered output valid
//   next_layer_data   registered output beat
//   next_layer_pid    producer index of the current output beat
// Handshake: a beat moves when valid and rdy are both high on a rising edge;
// a producer keeps its data stable while valid is high and rdy is low.
module layer_stream_arbiter
  import layer_stream_arbiter_pkg::*;
#(
  parameter int  BIT_WIDTH = 8,
  parameter int  NUM_PORT  = 4,
  parameter int  BURST_LEN = 4,
  localparam int PID_W     = (arb_clog2(NUM_PORT) < 1) ? 1 : int'(arb_clog2(NUM_PORT)),
  localparam int CNT_W     = (arb_clog2(BURST_LEN + 1) < 1) ? 1 : int'(arb_clog2(BURST_LEN + 1))
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORT-1:0]           in_valid,
  output logic [NUM_PORT-1:0]           in_rdy,
  input  logic [NUM_PORT*BIT_WIDTH-1:0] in_data,
  input  logic                          next_layer_rdy,
  output logic                          next_layer_valid,
  output logic [BIT_WIDTH-1:0]          next_layer_data,
  output logic [PID_W-1:0]              next_layer_pid
);

  arb_state_e           state_q, state_d;
  logic [PID_W-1:0]     ptr_q, ptr_d;
  logic [PID_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
  logic [PID_W-1:0]     out_pid_q, out_pid_d;

  logic [NUM_PORT-1:0]  pick_onehot;
  logic [PID_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 load_en;
  logic [PID_W-1:0]     sel;
  logic                 sel_ok;
  logic                 xfer;
  logic [BIT_WIDTH-1:0] sel_data;

  function automatic logic [PID_W-1:0] next_port(input logic [PID_W-1:0] p);
    return (p == PID_W'(NUM_PORT - 1)) ? '0 : p + PID_W'(1);
  endfunction

  layer_stream_arbiter_rr_pick #(
    .NUM_PORT (NUM_PORT),
    .PID_W    (PID_W)
  ) u_pick (
    .req    (in_valid),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // Grant path: the burst owner is fixed while LOCKED; otherwise the rotating pick.
  always_comb begin
    load_en  = !out_valid_q || next_layer_rdy;
    sel      = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
    sel_ok   = (state_q == ARB_LOCKED) || (pick_any && (pick_onehot != '0));
    in_rdy   = '0;
    if (rst_n && sel_ok) in_rdy[sel] = load_en;
    xfer     = sel_ok && in_valid[sel] && load_en;
    sel_data = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (sel == PID_W'(i)) sel_data = in_data[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pid_d   = out_pid_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_pid_d   = sel;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          if (BURST_LEN == 1) begin
            ptr_d = next_port(sel);
          end else begin
            state_d = ARB_LOCKED;
            owner_d = sel;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        // Owner withdrew: release immediately, costing one idle cycle.
        if (!in_valid[owner_q]) begin
          state_d = ARB_IDLE;
          ptr_d   = next_port(owner_q);
          cnt_d   = '0;
        end else if (xfer) begin
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            state_d = ARB_IDLE;
            ptr_d   = next_port(owner_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pid_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pid_q   <= out_pid_d;
    end
  end

  assign next_layer_valid = out_valid_q;
  assign next_layer_data  = out_data_q;
  assign next_layer_pid   = out_pid_q;

endmodule
